// File: rtl/vram_text_fetch.sv
// vram_text_fetch
// Display-side reader for the 8 KB text-mode VRAM (80x30 cells of 8x16 pixels,
// 640x480). Fetches a character and attribute byte per cell, looks up the
// glyph row in the external font ROM and shifts out one 4-bit colour index per
// pixel clock, aligned to the timing generator's hCount/vCount.
//
// Ports
//   clk            pixel clock, all state on the rising edge
//   nrst           asynchronous active-low reset
//   hCount/vCount  timing generator counters (0..H_TOTAL-1 / 0..V_TOTAL-1)
//   displayAddr    registered VRAM read address
//   displayRdData  VRAM data, valid the cycle after its address
//   fontAddr       registered font ROM address {char, scanline}
//   fontData       glyph row (MSB = leftmost pixel), valid the cycle after fontAddr
//   pixelColor     colour index for the current hCount, 0 when blank
//   cursorCol/Row  cursor cell (only with VRAM_TEXT_FETCH_CURSOR_EN)
//
// Optional feature: define VRAM_TEXT_FETCH_CURSOR_EN to add a blinking
// block cursor on scanlines 14-15 of the cursor cell.
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no line being fetched; displayAddr holds its last value
// FETCH   | fetching cells 0..79 of the next line, phase = hCount[2:0]

module vram_text_fetch #(
  parameter int H_TOTAL   = 800,
  parameter int H_VISIBLE = 640,
  parameter int V_TOTAL   = 525,
  parameter int V_VISIBLE = 480
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [9:0]  hCount,
  input  logic [9:0]  vCount,
  output logic [12:0] displayAddr,
  input  logic [7:0]  displayRdData,
  output logic [11:0] fontAddr,
  input  logic [7:0]  fontData,
`ifdef VRAM_TEXT_FETCH_CURSOR_EN
  input  logic [6:0]  cursorCol,
  input  logic [4:0]  cursorRow,
`endif
  output logic [3:0]  pixelColor
);

  typedef enum logic {ST_IDLE, ST_FETCH} state_t;

  state_t      r_state;
  logic [6:0]  r_col;
  logic [12:0] r_base;
  logic [3:0]  r_scan;
  logic [7:0]  r_attr_next;
  logic [7:0]  r_pat_next;
  logic [7:0]  r_attr_cur;
  logic [7:0]  r_shifter;
  logic        r_valid;
  logic [2:0]  r_shift_cnt;

  logic        w_line_start;
  logic [9:0]  w_next_line;
  logic [4:0]  w_next_row;
  logic [12:0] w_next_base;
  logic [2:0]  w_phase;
  logic [12:0] w_cell_addr;
  logic [6:0]  w_col_inc;
  logic [12:0] w_next_cell_addr;

  // The line-start decision is taken on the edge that opens hCount H_TOTAL-8,
  // so the character address of cell 0 is already on the bus during that
  // cycle and every later address is registered one edge ahead of its phase.
  assign w_line_start     = (hCount == 10'(H_TOTAL - 9));
  assign w_next_line      = (vCount == 10'(V_TOTAL - 1)) ? 10'd0 : vCount + 10'd1;
  assign w_next_row       = w_next_line[8:4];
  // row*160 = row*128 + row*32
  assign w_next_base      = {1'b0, w_next_row, 7'b0} + {3'b0, w_next_row, 5'b0};
  assign w_phase          = hCount[2:0];
  assign w_cell_addr      = r_base + {5'b0, r_col, 1'b0};
  assign w_col_inc        = r_col + 7'd1;
  assign w_next_cell_addr = r_base + {5'b0, w_col_inc, 1'b0};

`ifdef VRAM_TEXT_FETCH_CURSOR_EN
  logic [5:0] r_frame_cnt;
  logic [4:0] r_row;
  logic       r_cur_hit;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_col       <= '0;
      r_base      <= '0;
      r_scan      <= '0;
      r_attr_next <= '0;
      r_pat_next  <= '0;
      r_attr_cur  <= '0;
      r_shifter   <= '0;
      r_valid     <= 1'b0;
      r_shift_cnt <= '0;
      displayAddr <= '0;
      fontAddr    <= '0;
`ifdef VRAM_TEXT_FETCH_CURSOR_EN
      r_frame_cnt <= '0;
      r_row       <= '0;
      r_cur_hit   <= 1'b0;
`endif
    end else begin
      // Default: shift out one pixel; a cell loaded 8 shifts ago with no
      // successor goes blank.
      r_shifter <= {r_shifter[6:0], 1'b0};
      if (r_valid) begin
        r_shift_cnt <= r_shift_cnt + 3'd1;
        if (r_shift_cnt == 3'd7) r_valid <= 1'b0;
      end

`ifdef VRAM_TEXT_FETCH_CURSOR_EN
      if (hCount == 10'd0 && vCount == 10'(V_VISIBLE)) r_frame_cnt <= r_frame_cnt + 6'd1;
`endif

      if (w_line_start) begin
        // Restarting here also abandons a line disturbed by an hCount jump.
        r_scan <= w_next_line[3:0];
`ifdef VRAM_TEXT_FETCH_CURSOR_EN
        r_row  <= w_next_row;
`endif
        if (w_next_line < 10'(V_VISIBLE)) begin
          r_state     <= ST_FETCH;
          r_col       <= '0;
          r_base      <= w_next_base;
          displayAddr <= w_next_base;
        end else begin
          r_state <= ST_IDLE;
        end
      end else if (r_state == ST_FETCH) begin
        case (w_phase)
          3'd0: displayAddr <= w_cell_addr + 13'd1;
          // The character byte goes straight into the font address register,
          // which is where it is held for the glyph lookup.
          3'd1: fontAddr    <= {displayRdData, r_scan};
          3'd2: r_attr_next <= displayRdData;
          3'd3: r_pat_next  <= fontData;
          3'd7: begin
            r_shifter   <= r_pat_next;
            r_attr_cur  <= r_attr_next;
            r_valid     <= 1'b1;
            r_shift_cnt <= '0;
            r_col       <= w_col_inc;
`ifdef VRAM_TEXT_FETCH_CURSOR_EN
            r_cur_hit   <= (r_col == cursorCol) && (r_row == cursorRow) && (r_scan[3:1] == 3'b111);
`endif
            if (r_col == 7'd79) r_state     <= ST_IDLE;
            else                displayAddr <= w_next_cell_addr;
          end
          default: ;
        endcase
      end
    end
  end

  // Lit glyph pixels take the low (foreground) nibble.
`ifdef VRAM_TEXT_FETCH_CURSOR_EN
  logic w_swap;
  assign w_swap     = r_frame_cnt[5] & r_cur_hit;
  assign pixelColor = !r_valid ? 4'd0 :
                      ((r_shifter[7] ^ w_swap) ? r_attr_cur[3:0] : r_attr_cur[7:4]);
`else
  assign pixelColor = !r_valid ? 4'd0 :
                      (r_shifter[7] ? r_attr_cur[3:0] : r_attr_cur[7:4]);
`endif

endmodule

// File: tb/tb_vram_text_fetch.sv
module tb_vram_text_fetch;

  localparam int H_TOTAL   = 800;
  localparam int V_TOTAL   = 525;

  logic        clk;
  logic        nrst;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic [12:0] displayAddr;
  logic [7:0]  displayRdData;
  logic [11:0] fontAddr;
  logic [7:0]  fontData;
  logic [3:0]  pixelColor;

  vram_text_fetch dut (
    .clk           (clk),
    .nrst          (nrst),
    .hCount        (hCount),
    .vCount        (vCount),
    .displayAddr   (displayAddr),
    .displayRdData (displayRdData),
    .fontAddr      (fontAddr),
    .fontData      (fontData),
`ifdef VRAM_TEXT_FETCH_CURSOR_EN
    .cursorCol     (7'd0),
    .cursorRow     (5'd0),
`endif
    .pixelColor    (pixelColor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] vram [8192];
  logic [7:0] font_rom [4096];
  logic [3:0] sb_q [$];
  logic [3:0] first_cell [8];

  int v, h;
  int blank_line, blank_h;
  int n_cmp, n_err;
  bit jumped;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (line %0d hCount %0d)", tag, obs, exp, v, h);
    end
  endtask

  function automatic logic [3:0] exp_pix(input int line, input int hc);
    int base, col;
    logic [7:0] ch, at, pat;
    if (line == blank_line && hc >= blank_h) return 4'd0;
    if (line >= 480 || hc >= 640) return 4'd0;
    base = (line / 16) * 160;
    col  = hc / 8;
    ch   = vram[base + 2 * col];
    at   = vram[base + 2 * col + 1];
    pat  = font_rom[int'(ch) * 16 + (line % 16)];
    return pat[7 - (hc % 8)] ? at[3:0] : at[7:4];
  endfunction

  // One pixel clock: memories answer the address held during the last
  // cycle, the timing counters advance, expected pixel is queued and
  // compared against the DUT mid-cycle.
  task automatic step();
    logic [12:0] a;
    logic [11:0] f;
    a = displayAddr;
    f = fontAddr;
    @(posedge clk);
    #1;
    if (h == H_TOTAL - 1) begin
      h = 0;
      v = (v == V_TOTAL - 1) ? 0 : v + 1;
    end else begin
      h++;
    end
    hCount = 10'(h);
    vCount = 10'(v);
    displayRdData = vram[a];
    fontData      = font_rom[f];
    if (v == 10 && h == 300) nrst = 1'b0;
    if (v == 10 && h == 305) nrst = 1'b1;
    sb_q.push_back(exp_pix(v, h));
    #1;
    check_val("pixel", 32'(pixelColor), 32'(sb_q.pop_front()));

    if (v == 524 && h == 792) check_val("addr_c0_char", 32'(displayAddr), 32'd0);
    if (v == 524 && h == 793) check_val("addr_c0_attr", 32'(displayAddr), 32'd1);
    if (v == 524 && h == 794) check_val("font_c0", 32'(fontAddr), 32'h410);
    if (v == 0 && h < 8)      check_val("pix_a5", 32'(pixelColor), 32'(first_cell[h]));
    if (v == 479 && h == 624) check_val("addr_c79_char", 32'(displayAddr), 32'd4798);
    if (v == 479 && h == 625) check_val("addr_c79_attr", 32'(displayAddr), 32'd4799);
    if (v == 479 && h == 626) check_val("font_c79", 32'(fontAddr), {20'd0, vram[4798], 4'hF});
    if (v == 479 && h == 640) check_val("pix_640", 32'(pixelColor), 32'd0);
    if (jumped && ((v >= 480 && v < 524 && h == 0) || (v == 524 && h == 791)))
      check_val("addr_hold", 32'(displayAddr), 32'd4799);
    if (v == 10 && h == 300) begin
      check_val("rst_pix", 32'(pixelColor), 32'd0);
      check_val("rst_daddr", 32'(displayAddr), 32'd0);
      check_val("rst_faddr", 32'(fontAddr), 32'd0);
    end
    if (v == 11 && h < 8) check_val("post_rst_pix", 32'(pixelColor), 32'(exp_pix(11, h)));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    jumped = 1'b0;
    blank_line = 1023;
    blank_h = 0;
    for (int i = 0; i < 8192; i++) vram[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) font_rom[i] = 8'($urandom);
    vram[0] = 8'h41;
    vram[1] = 8'h1E;
    font_rom[12'h410] = 8'hA5;
    first_cell = '{4'hE, 4'h1, 4'hE, 4'h1, 4'h1, 4'hE, 4'h1, 4'hE};

    nrst = 1'b0;
    h = 690;
    v = 524;
    hCount = 10'(h);
    vCount = 10'(v);
    displayRdData = '0;
    fontData = '0;

    step();
    check_val("reset_daddr", 32'(displayAddr), 32'd0);
    check_val("reset_faddr", 32'(fontAddr), 32'd0);
    check_val("reset_pix", 32'(pixelColor), 32'd0);
    repeat (3) step();
    nrst = 1'b1;

    // first visible line from the wrap of line 524
    while (!(v == 1 && h == 700)) step();

    // jump into the last text row while the fetcher is idle
    v = 478;
    vCount = 10'(v);
    jumped = 1'b1;
    while (!(v == 10 && h == 299)) step();

    // reset pulse on line 10, hCount 300..304
    blank_line = 10;
    blank_h = 300;
    while (!(v == 11 && h == 700)) step();

    // blank glyph on attribute 0x00: every pixel must come out as colour 0
    for (int i = 0; i < 4800; i += 2) begin
      vram[i]     = 8'h80;
      vram[i + 1] = 8'h00;
    end
    for (int s = 0; s < 16; s++) font_rom[12'h800 + s] = 8'hFF;
    while (!(v == 13 && h == 0)) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
